// File: rtl/ps2_code_if.sv
// Scan-code handshake between the PS/2 receiver and the keyboard decoder.
// The master presents the FIFO head; the slave accepts it with code_ready.
interface ps2_code_if;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ready;

    modport master (output code, output code_valid, input code_ready);
    modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard frame receiver: synchronizes and deglitches the PS/2 lines,
// assembles 11-bit frames on filtered clock falls, checks start/parity/stop,
// aborts stalled frames, and queues good scan codes in a small FWFT FIFO.
module ps2_rx_ctrl #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 20000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    ps2_code_if.master  code_if,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overflow,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHECK} state_e;

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [3:0]    filt_cnt_q, filt_cnt_d;
    logic          fall;

    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          push;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          empty, full, pop, wr_en;

    // Two-flop synchronizers; lines idle high, so reset to 1.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // Glitch filter: follow the synchronized clock only after FILTER_LEN differing cycles.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == 4'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
            else                                  filt_cnt_d = filt_cnt_q + 4'd1;
        end
    end

    // Filtered clock, its one-cycle-old copy, and the debounce counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    // Frame FSM next state: start detect, bit assembly, timeout, final check.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        frame_d      = frame_q;
        to_cnt_d     = to_cnt_q;
        push         = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (fall) begin
                    if (!data_sync_q[1]) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 4'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (fall) begin
                    to_cnt_d  = '0;
                    // Bits 1..10 enter at the top; after ten shifts [7:0]=data, [8]=parity, [9]=stop.
                    frame_d   = {data_sync_q[1], frame_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd10) begin
                        state_d   = S_CHECK;
                        bit_cnt_d = '0;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    to_cnt_d    = '0;
                    state_d     = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!frame_q[9])            frame_err_d  = 1'b1;
                else if (!(^frame_q[8:0]))  parity_err_d = 1'b1;
                else                        push         = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO control: a simultaneous pop frees the slot even when full.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop        = !empty && code_if.code_ready;
        wr_en      = push && (!full || pop);
        overflow_d = push && full && !pop;
    end

    // FSM, timeout, pointer and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            frame_q      <= '0;
            to_cnt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_q      <= frame_d;
            to_cnt_q     <= to_cnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage write.
    // NOTE: storage has no reset; the pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= frame_q[7:0];
    end

    assign code_if.code       = empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];
    assign code_if.code_valid = !empty;
    assign parity_err         = parity_err_q;
    assign frame_err          = frame_err_q;
    assign overflow           = overflow_q;
    assign busy               = (state_q != S_IDLE);

endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
Controller that sequences PS/2 keyboard frame reception for the keyboard reader path. It synchronizes and filters the raw ps2_clk/ps2_data lines, clocks each bit on a filtered ps2_clk falling edge, and tracks the 11-bit frame position. It checks the start, parity and stop bits, and recovers from stalled frames with a timeout. Validated scan codes are buffered in a small FIFO and handed to the keyboard decoder through a valid/ready handshake.

Parameters:
FILTER_LEN, 4, consecutive system-clock cycles the synchronized ps2_clk must hold a new level before the filtered level changes (range 2-15)
TIMEOUT_CYC, 20000, maximum cycles allowed between falling edges inside a frame before the frame is aborted
FIFO_DEPTH, 4, scan-code buffer entries (power of 2, minimum 2)

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock line (asynchronous)
ps2_data  in  1  raw PS/2 data line (asynchronous)
code  out  8  scan code at the FIFO head
code_valid  out  1  FIFO not empty
code_ready  in  1  consumer accepts code when code_valid && code_ready
parity_err  out  1  1-cycle pulse: odd-parity check failed, frame dropped
frame_err  out  1  1-cycle pulse: bad start bit, bad stop bit, or timeout
overflow  out  1  1-cycle pulse: valid frame dropped because the FIFO was full
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; bit count=0; timeout counter=0; FIFO emptied; synchronizers=1; filtered clk=1. Outputs: code=0, code_valid=0, all pulse outputs=0, busy=0. Reset mid-frame discards the partial frame and all buffered codes.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-flop synchronizer. Filtered clk toggles only after the synchronized clk differs from it for FILTER_LEN consecutive cycles.
- Edge: fall = filtered clk transitions 1->0, a 1-cycle strobe. Data is sampled from the synchronized ps2_data in the fall cycle.
- FSM states: IDLE, DATA, CHECK.
  - IDLE: on fall with data=0 (start bit), go to DATA with bit count=1. On fall with data=1, pulse frame_err and stay in IDLE.
  - DATA: each fall shifts the sampled bit into the frame register, LSB-first for data bits 1-8, and increments the count. When the 11th bit (stop) is sampled, go to CHECK next cycle.
  - DATA timeout: the counter clears on every fall. If it reaches TIMEOUT_CYC-1 with no fall, pulse frame_err, clear the count, and go to IDLE.
  - CHECK (exactly 1 cycle, then IDLE):
    - stop bit=0: pulse frame_err.
    - XOR of the 8 data bits and the parity bit = 0: pulse parity_err.
    - Stop error takes priority; only one error pulse is issued per frame.
    - Otherwise, write the data byte to the FIFO.
- Latency: 11th fall cycle E -> CHECK at E+1 -> code_valid=1 and code valid at E+2 when the FIFO was empty.
- FIFO: first-word-fall-through; code shows the head entry.
  - Pop on code_valid && code_ready. Pop while empty is impossible by definition.
  - Push and pop in the same cycle: both happen and the occupancy is unchanged. This also applies when full, so the push is accepted with no overflow.
  - Push when full with no pop: byte dropped, overflow pulses for 1 cycle, existing contents untouched.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with an extra pointer bit or a counter 0..FIFO_DEPTH.
- A fall that arrives during CHECK is ignored (not possible at legal PS/2 rates).

Test Plan:
- Send frame for 0x1C (bits: 0, 0,0,1,1,1,0,0,0, parity 0, stop 1) at ~12 kHz with code_ready=1 -> code=0x1C, code_valid for exactly 1 cycle, 2 cycles after the 11th filtered fall; no error pulses.
- Same frame with parity bit=1 -> exactly one parity_err pulse, code_valid stays 0. Then a valid 0xF0 frame (parity 1) -> code=0xF0 delivered.
- Send 5 bits then hold ps2_clk high for TIMEOUT_CYC+10 cycles -> one frame_err pulse, busy falls. Following valid 0x1C frame -> received correctly.
- code_ready=0, send 0x11,0x12,0x13,0x14,0x15 -> code_valid=1, one overflow pulse on 0x15. Raising code_ready pops 0x11,0x12,0x13,0x14 in order, then code_valid=0.
- 2-cycle low glitch on ps2_clk in IDLE with FILTER_LEN=4 -> no fall, no state change. A frame whose stop bit=0 -> frame_err pulse, nothing pushed.
- Assert reset_n=0 mid-frame (after 6 bits) with 2 codes buffered -> code_valid=0, busy=0 immediately. After release, a full 0x1C frame -> only 0x1C delivered.
